access_code_correlator: RTL and testbench

// Receive-side access-code correlator; the receive counterpart of the header/access-code transmit path.

---
 rtl/access_code_correlator.sv | 167 ++++++++++++++++
 tb/tb_access_code_correlator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/access_code_correlator.sv
// ============================================================================
//  Module      : access_code_correlator
//  Description : Receive-side access-code correlator. Shifts demodulated bits
//                in on the 1 us strobe, compares the last 64 bits against the
//                selected sync word and declares sync when the Hamming
//                distance is within the programmed threshold.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module access_code_correlator #(
  parameter int WIN_W    = 12,
  parameter int SYNC_LEN = 64
) (
  input  logic                clk_6M,
  input  logic                rst,
  input  logic                p_1us,
  input  logic                rxbit,
  input  logic [SYNC_LEN-1:0] syncword,
  input  logic [3:0]          corr_maxerr,
  input  logic [WIN_W-1:0]    search_win_us,
  input  logic                search_st_p,
  input  logic                search_stop,
  output logic                search_active,
  output logic                sync_found,
  output logic                rx_trailer_st_p,
  output logic                corr_timeout_p,
  output logic [6:0]          corr_errs
);

  localparam logic [6:0] C_FULL_CNT = 7'(SYNC_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [SYNC_LEN-1:0] r_shreg;
  logic [SYNC_LEN-1:0] w_diff;
  logic [6:0]          r_bit_cnt;
  logic [6:0]          w_bit_cnt_inc;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [WIN_W-1:0]    w_win_cnt_inc;
  logic [6:0]          w_dist;
  logic [6:0]          r_dist;
  logic [6:0]          r_errs;
  logic                r_shifted;   // a new bit entered the window last edge
  logic                r_match;     // registered qualified compare
  logic                r_to_defer;  // window expired while the final compare was in flight
  logic                r_trailer;
  logic                r_timeout;
  logic                w_shift;
  logic                w_will_cmp;
  logic                w_win_hit;
  logic                w_cmp_ok;
  logic                w_timeout;

  assign w_diff        = r_shreg ^ syncword;
  assign w_bit_cnt_inc = (r_bit_cnt == C_FULL_CNT) ? r_bit_cnt : r_bit_cnt + 7'd1;
  assign w_win_cnt_inc = (&r_win_cnt) ? r_win_cnt
                                      : r_win_cnt + {{(WIN_W-1){1'b0}}, 1'b1};

  // A shift happens only on a strobe in SEARCH when no stop/restart overrides it
  assign w_shift    = (r_state == ST_SEARCH) && p_1us && !search_stop && !search_st_p;
  // This shift completes (or keeps) a full window, so a compare follows next cycle
  assign w_will_cmp = w_shift && (w_bit_cnt_inc == C_FULL_CNT);
  assign w_win_hit  = w_shift && (search_win_us != '0) && (w_win_cnt_inc == search_win_us);
  assign w_cmp_ok   = r_shifted && (r_state == ST_SEARCH) && (r_bit_cnt == C_FULL_CNT) &&
                      (w_dist <= {3'd0, corr_maxerr});
  // Window expiry fires at once unless a compare is in flight; then it waits
  // one cycle so that a match on the final bit takes precedence.
  assign w_timeout  = (r_state == ST_SEARCH) && !search_stop && !search_st_p && !r_match &&
                      ((w_win_hit && !w_will_cmp) || (r_to_defer && !w_cmp_ok));

  // Hamming distance between the received window and the expected word
  always_comb begin
    w_dist = 7'd0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      w_dist = w_dist + {6'd0, w_diff[i]};
    end
  end

  // State register
  always_ff @(posedge clk_6M) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic and state-decoded status outputs
  always_comb begin
    w_state_nx    = r_state;
    search_active = 1'b0;
    sync_found    = 1'b0;
    if (search_stop) begin
      w_state_nx = ST_IDLE;
    end else if (search_st_p) begin
      w_state_nx = ST_SEARCH;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (r_match)        w_state_nx = ST_LOCKED;
          else if (w_timeout) w_state_nx = ST_IDLE;
        end
        default: w_state_nx = r_state;
      endcase
    end
    search_active = (r_state == ST_SEARCH);
    sync_found    = (r_state == ST_LOCKED);
  end

  // Shift register, counters, compare pipeline and strobe outputs
  always_ff @(posedge clk_6M) begin
    if (rst) begin
      r_shreg    <= '0;
      r_bit_cnt  <= 7'd0;
      r_win_cnt  <= '0;
      r_shifted  <= 1'b0;
      r_match    <= 1'b0;
      r_to_defer <= 1'b0;
      r_timeout  <= 1'b0;
      r_dist     <= 7'd0;
      r_errs     <= 7'd0;
      r_trailer  <= 1'b0;
    end else begin
      r_shifted  <= w_shift;
      r_match    <= w_cmp_ok && !search_stop && !search_st_p;
      r_to_defer <= w_win_hit && w_will_cmp;
      r_timeout  <= w_timeout;
      if (r_shifted) r_dist <= w_dist;

      if (search_stop) begin
        r_trailer <= 1'b0;
        r_errs    <= 7'd0;
      end else if (search_st_p) begin
        r_shreg   <= '0;
        r_bit_cnt <= 7'd0;
        r_win_cnt <= '0;
        r_trailer <= 1'b0;
        r_errs    <= 7'd0;
      end else begin
        if (w_shift) begin
          r_shreg   <= {rxbit, r_shreg[SYNC_LEN-1:1]};
          r_bit_cnt <= w_bit_cnt_inc;
          r_win_cnt <= w_win_cnt_inc;
        end
        // Trailer rises with the lock and survives exactly one strobe
        if ((r_state == ST_SEARCH) && r_match) begin
          r_trailer <= 1'b1;
          r_errs    <= r_dist;
        end else if (r_trailer && p_1us) begin
          r_trailer <= 1'b0;
        end
      end
    end
  end

  assign rx_trailer_st_p = r_trailer;
  assign corr_timeout_p  = r_timeout;
  assign corr_errs       = r_errs;

endmodule

`default_nettype wire

// File: tb/tb_access_code_correlator.sv
// ============================================================================
//  Module      : tb_access_code_correlator
//  Description : Self-checking bench for access_code_correlator. Bit streams
//                are built from random and sync-word bits; a stream-level
//                model predicts the strobe at which sync or timeout occurs,
//                and every cycle's outputs are checked against that event.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_access_code_correlator;

  localparam logic [63:0] SW1 = 64'hA5A5_F00F_1234_9876;
  localparam logic [63:0] SW2 = 64'hC3A5_96F0_1E00_0000;

  logic        clk_6M = 1'b0;
  logic        rst = 1'b1;
  logic        p_1us = 1'b0;
  logic        rxbit = 1'b0;
  logic [63:0] syncword = 64'd0;
  logic [3:0]  corr_maxerr = 4'd0;
  logic [11:0] search_win_us = 12'd0;
  logic        search_st_p = 1'b0;
  logic        search_stop = 1'b0;
  logic        search_active;
  logic        sync_found;
  logic        rx_trailer_st_p;
  logic        corr_timeout_p;
  logic [6:0]  corr_errs;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ev_kind = 0;   // 0 none yet, 1 lock, 2 timeout
  int          ev_edge = 0;
  logic [6:0]  ev_dist = 7'd0;
  bit          q_bits[$];
  logic [63:0] mask;

  access_code_correlator #(.WIN_W(12), .SYNC_LEN(64)) dut (
    .clk_6M          (clk_6M),
    .rst             (rst),
    .p_1us           (p_1us),
    .rxbit           (rxbit),
    .syncword        (syncword),
    .corr_maxerr     (corr_maxerr),
    .search_win_us   (search_win_us),
    .search_st_p     (search_st_p),
    .search_stop     (search_stop),
    .search_active   (search_active),
    .sync_found      (sync_found),
    .rx_trailer_st_p (rx_trailer_st_p),
    .corr_timeout_p  (corr_timeout_p),
    .corr_errs       (corr_errs)
  );

  always #5 clk_6M = ~clk_6M;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_6M);
    cyc++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/active"},  7'(search_active),   7'd0);
    chk({tag, "/found"},   7'(sync_found),      7'd0);
    chk({tag, "/trailer"}, 7'(rx_trailer_st_p), 7'd0);
    chk({tag, "/timeout"}, 7'(corr_timeout_p),  7'd0);
    chk({tag, "/errs"},    corr_errs,           7'd0);
  endtask

  // Expected outputs derive only from the predicted event and its edge
  task automatic check_outputs(input string tag);
    logic       e_act, e_found, e_tr, e_to;
    logic [6:0] e_errs;
    e_act = 1'b1; e_found = 1'b0; e_tr = 1'b0; e_to = 1'b0; e_errs = 7'd0;
    if (ev_kind == 1 && cyc >= ev_edge) begin
      e_act = 1'b0; e_found = 1'b1; e_errs = ev_dist;
      e_tr  = (cyc < ev_edge + 4);   // next strobe edge is 4 cycles after lock
    end
    if (ev_kind == 2 && cyc >= ev_edge) begin
      e_act = 1'b0;
      e_to  = (cyc == ev_edge);
    end
    chk({tag, "/active"},  7'(search_active),   7'(e_act));
    chk({tag, "/found"},   7'(sync_found),      7'(e_found));
    chk({tag, "/trailer"}, 7'(rx_trailer_st_p), 7'(e_tr));
    chk({tag, "/timeout"}, 7'(corr_timeout_p),  7'(e_to));
    chk({tag, "/errs"},    corr_errs,           e_errs);
  endtask

  task automatic push_word(input logic [63:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) q_bits.push_back(w[i]);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) q_bits.push_back(bit'($urandom_range(1)));
  endtask

  task automatic make_mask(input int nflip);
    int p;
    mask = 64'd0;
    for (int i = 0; i < nflip; i++) begin
      do p = $urandom_range(63); while (mask[p]);
      mask[p] = 1'b1;
    end
  endtask

  // abort_k: 0 none, -1 at the predicted event strobe, >0 at that strobe.
  // abort_kind: 1 search_stop, 2 rst.
  task automatic run_search(input logic [63:0] sw, input logic [3:0] me, input logic [11:0] win,
                            input int n_bits, input int abort_k, input int abort_kind,
                            input string tag);
    int m_kind, m_k, m_dist, d, coinc, ab_k;
    while (q_bits.size() < n_bits) q_bits.push_back(bit'($urandom_range(1)));
    // Stream model: first strobe whose last 64 bits are close enough, else window end
    m_kind = 0; m_k = 0; m_dist = 0;
    for (int k = 1; k <= n_bits; k++) begin
      if (k >= 64) begin
        d = 0;
        for (int j = 0; j < 64; j++) d += int'(q_bits[k-64+j] ^ sw[j]);
        if (d <= int'(me)) begin m_kind = 1; m_k = k; m_dist = d; break; end
      end
      if (win != 12'd0 && k == int'(win)) begin m_kind = 2; m_k = k; break; end
    end
    ab_k = (abort_k == -1) ? m_k : abort_k;

    syncword = sw; corr_maxerr = me; search_win_us = win;
    ev_kind = 0; ev_edge = 0; ev_dist = 7'd0; coinc = 0;
    search_st_p = 1'b1;
    tick();
    search_st_p = 1'b0;
    check_outputs({tag, "/start"});
    for (int k = 1; k <= n_bits; k++) begin
      p_1us = 1'b1;
      rxbit = q_bits[k-1];
      if (rx_trailer_st_p) coinc++;
      tick();
      p_1us = 1'b0;
      if (k == m_k && m_kind == 1) begin
        ev_kind = 1; ev_edge = cyc + 2; ev_dist = 7'(m_dist);
      end
      if (k == m_k && m_kind == 2) begin
        ev_kind = 2; ev_edge = cyc + ((k >= 64) ? 1 : 0);
      end
      check_outputs(tag);
      if (k == ab_k && abort_kind != 0) begin
        if (abort_kind == 1) search_stop = 1'b1; else rst = 1'b1;
        tick();
        search_stop = 1'b0; rst = 1'b0;
        chk_zero({tag, "/abort"});
        for (int i = 0; i < 11; i++) begin
          tick();
          chk_zero({tag, "/after"});
        end
        ev_kind = 0;
        q_bits.delete();
        return;
      end
      for (int i = 0; i < 5; i++) begin
        tick();
        check_outputs(tag);
      end
    end
    if (m_kind == 1 && m_k < n_bits) chk({tag, "/coincide"}, 7'(coinc), 7'd1);
    q_bits.delete();
  endtask

  task automatic stop_and_check(input string tag);
    search_stop = 1'b1;
    tick();
    search_stop = 1'b0;
    chk_zero(tag);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // Clean sync after a 4-bit preamble
    push_rand(4); push_word(SW1, 0, 63);
    run_search(SW1, 4'd0, 12'd0, 71, 0, 0, "s1_clean");

    // Three flipped bits: accepted at threshold 3, rejected at 2
    make_mask(3);
    push_rand(4); push_word(SW1 ^ mask, 0, 63);
    run_search(SW1, 4'd3, 12'd0, 71, 0, 0, "s2_me3");
    push_rand(4); push_word(SW1 ^ mask, 0, 63);
    run_search(SW1, 4'd2, 12'd0, 72, 0, 0, "s2_me2");
    stop_and_check("s2_stop");

    // Window of 20 strobes, random bits
    run_search(SW1, 4'd0, 12'd20, 26, 0, 0, "s3_timeout");

    // Sync completes on the final window strobe; then same window without sync
    push_rand(4); push_word(SW1, 0, 63);
    run_search(SW1, 4'd0, 12'd68, 71, 0, 0, "s4_lastwin");
    make_mask(10);
    push_rand(4); push_word(SW1 ^ mask, 0, 63);
    run_search(SW1, 4'd0, 12'd68, 71, 0, 0, "s4_defer");

    // Stop one cycle after the final sync bit; reset in the middle of a search
    push_rand(4); push_word(SW1, 0, 63);
    run_search(SW1, 4'd0, 12'd0, 68, -1, 1, "s5_stop");
    push_rand(4); push_word(SW1, 0, 63);
    run_search(SW1, 4'd0, 12'd0, 68, 30, 2, "s5_rst");

    // Restart while locked; the window matches after 40 bits but must not lock
    push_rand(4); push_word(SW2, 0, 63);
    run_search(SW2, 4'd0, 12'd0, 71, 0, 0, "s6_first");
    push_word(SW2, 24, 63); push_word(SW2, 0, 63);
    run_search(SW2, 4'd0, 12'd0, 107, 0, 0, "s6_relock");
    stop_and_check("s6_stop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
